// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-detected, maskable, fixed-priority interrupt controller with CPU handshake
module interrupt_controller #(
    parameter int NSRC = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic [31:0]     address,
    input  logic [31:0]     data,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            IntTaken,
    output logic            InterruptRequest,
    output logic [4:0]      cause,
    output logic [31:0]     rdata,
    output logic            ICAddress
);
    localparam logic [31:0] MASK_ADDR  = 32'hffff0020;
    localparam logic [31:0] PEND_ADDR  = 32'hffff0024;
    localparam logic [31:0] ACK_ADDR   = 32'hffff0028;
    localparam logic [31:0] CAUSE_ADDR = 32'hffff002c;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] mask_q, mask_d, pend_q, pend_d, prev_q, eligible, ackclr;
    logic [4:0]      cur_q, cur_d, winner;
    logic [31:0]     elig_w, rd_val;
    logic            hit_mask, hit_pend, hit_ack, hit_cause, wr_ack, rd_hit;
    logic            unused_data;

    assign hit_mask    = address == MASK_ADDR;
    assign hit_pend    = address == PEND_ADDR;
    assign hit_ack     = address == ACK_ADDR;
    assign hit_cause   = address == CAUSE_ADDR;
    assign ICAddress   = hit_mask | hit_pend | hit_ack | hit_cause;
    assign wr_ack      = MemWrite & hit_ack;
    assign ackclr      = wr_ack ? data[NSRC-1:0] : '0;
    assign mask_d      = (MemWrite & hit_mask) ? data[NSRC-1:0] : mask_q;
    // a fresh rising edge wins over a same-cycle software clear
    assign pend_d      = (irq & ~prev_q) | (pend_q & ~ackclr);
    assign eligible    = pend_q & mask_q;
    assign elig_w      = 32'(eligible);
    assign unused_data = ^data;

    assign rd_hit = MemRead & (hit_mask | hit_pend | hit_cause);
    assign rd_val = hit_mask ? 32'(mask_q) : hit_pend ? 32'(pend_q) : 32'(cur_q);
    assign rdata  = rd_hit ? rd_val : 'z;

    assign InterruptRequest = state_q == REQ;
    assign cause            = cur_q;

    // lowest eligible index wins
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (eligible[i]) winner = 5'(i);
    end

    // request/service handshake; cur is frozen outside IDLE so there is no preemption
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        unique case (state_q)
            IDLE: if (|eligible) begin
                state_d = REQ;
                cur_d   = winner;
            end
            REQ: state_d = IntTaken ? SERVICE : !elig_w[cur_q] ? IDLE : REQ;
            SERVICE: state_d = wr_ack ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end

    // all state registers; reset overrides any simultaneous bus write
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            prev_q  <= irq;
            cur_q   <= cur_d;
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: table-driven directed check of the interrupt controller
module tb_interrupt_controller;
    localparam logic [31:0] M = 32'hffff0020;
    localparam logic [31:0] P = 32'hffff0024;
    localparam logic [31:0] A = 32'hffff0028;
    localparam logic [31:0] C = 32'hffff002c;

    typedef struct {
        logic        rst;
        logic [7:0]  irq;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic        it;
        logic        req;
        logic [4:0]  cause;
        int          chk;
        logic [31:0] rv;
    } vec_t;

    logic        clk = 0;
    logic        reset = 1;
    logic [7:0]  irq = '0;
    logic [31:0] address = '0, data = '0;
    logic        MemRead = 0, MemWrite = 0, IntTaken = 0;
    logic        InterruptRequest, ICAddress;
    logic [4:0]  cause;
    logic [31:0] rdata;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    interrupt_controller #(.NSRC(8)) dut (
        .clock(clk), .reset(reset), .irq(irq), .address(address), .data(data),
        .MemRead(MemRead), .MemWrite(MemWrite), .IntTaken(IntTaken),
        .InterruptRequest(InterruptRequest), .cause(cause), .rdata(rdata), .ICAddress(ICAddress)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [7:0] i, input logic [31:0] ad, input logic [31:0] d,
                       input logic rd, input logic wr, input logic it,
                       input logic req, input logic [4:0] cs, input int chk, input logic [31:0] rv);
        vq.push_back('{rst, i, ad, d, rd, wr, it, req, cs, chk, rv});
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; irq = v.irq; address = v.addr; data = v.data;
        MemRead = v.rd; MemWrite = v.wr; IntTaken = v.it;
    endtask

    initial begin
        vec_t idle_v;
        int   n;
        idle_v = '{0, 8'h00, 32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0, 32'h0};
        // basic flow
        add(1, 8'h00, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, M, 1,     0, 1, 0, 0, 0, 0, 0);
        add(0, 8'h01, M, 0,     1, 0, 0, 0, 0, 1, 32'h1);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 0, 1, 32'h1);
        add(0, 8'h00, 0, 0,     0, 0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 1, 1, 0, 0, 0);
        add(0, 8'h00, C, 0,     1, 0, 0, 0, 0, 1, 32'h0);
        add(0, 8'h00, A, 1,     0, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 0, 1, 32'h0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        // priority
        add(0, 8'h00, M, 8'hff, 0, 1, 0, 0, 0, 0, 0);
        add(0, 8'h24, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h24, P, 0,     1, 0, 0, 0, 0, 1, 32'h24);
        add(0, 8'h00, 0, 0,     0, 0, 0, 1, 2, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 1, 1, 2, 0, 0);
        add(0, 8'h00, A, 4,     0, 1, 0, 0, 2, 0, 0);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 2, 1, 32'h20);
        add(0, 8'h00, C, 0,     1, 0, 0, 1, 5, 1, 32'h5);
        add(0, 8'h00, 0, 0,     0, 0, 1, 1, 5, 0, 0);
        add(0, 8'h00, C, 0,     0, 0, 0, 0, 5, 2, 32'h5);
        add(0, 8'h00, A, 8'h20, 0, 1, 0, 0, 5, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 1, 0, 5, 0, 0);
        // masking, then clear by ACK while requesting
        add(0, 8'h00, M, 0,     0, 1, 0, 0, 5, 0, 0);
        add(0, 8'h08, 0, 0,     0, 0, 0, 0, 5, 0, 0);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 5, 1, 32'h8);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 5, 0, 0);
        add(0, 8'h00, M, 8,     0, 1, 0, 0, 5, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 5, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 1, 3, 0, 0);
        add(0, 8'h00, A, 8,     0, 1, 0, 1, 3, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 1, 3, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 3, 0, 0);
        // withdraw by masking during REQ
        add(0, 8'h00, M, 2,     0, 1, 0, 0, 3, 0, 0);
        add(0, 8'h02, 0, 0,     0, 0, 0, 0, 3, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 3, 0, 0);
        add(0, 8'h00, M, 0,     0, 1, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 1, 1, 0, 0);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 1, 1, 32'h2);
        add(0, 8'h00, 0, 0,     0, 0, 1, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 1, 0, 0);
        // same-cycle rise and clear on bit 4
        add(0, 8'h10, A, 8'h12, 0, 1, 0, 0, 1, 0, 0);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 1, 1, 32'h10);
        // reset during SERVICE with a colliding MASK write
        add(0, 8'h00, M, 8'h10, 0, 1, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0,     0, 0, 1, 1, 4, 0, 0);
        add(1, 8'h00, M, 8'hff, 0, 1, 0, 0, 4, 0, 0);
        add(0, 8'h00, M, 0,     1, 0, 0, 0, 0, 1, 32'h0);
        add(0, 8'h00, P, 0,     1, 0, 0, 0, 0, 1, 32'h0);
        // source already high when reset deasserts
        add(1, 8'h01, 0, 0,     0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h01, M, 1,     0, 1, 0, 0, 0, 0, 0);
        add(0, 8'h01, P, 0,     1, 0, 0, 0, 0, 1, 32'h1);
        add(0, 8'h01, 0, 0,     0, 0, 0, 1, 0, 0, 0);

        foreach (vq[k]) begin
            vec_t v;
            logic exp_ica;
            v = vq[k];
            @(negedge clk);
            drive(v);
            #1;
            n_vec++;
            exp_ica = v.addr inside {M, P, A, C};
            if (InterruptRequest !== v.req) begin
                n_bad++;
                $display("FAIL vec%0d req got %b exp %b", k, InterruptRequest, v.req);
            end
            if (cause !== v.cause) begin
                n_bad++;
                $display("FAIL vec%0d cause got %0d exp %0d", k, cause, v.cause);
            end
            if (ICAddress !== exp_ica) begin
                n_bad++;
                $display("FAIL vec%0d icaddr got %b exp %b", k, ICAddress, exp_ica);
            end
            if (v.chk == 1 && rdata !== v.rv) begin
                n_bad++;
                $display("FAIL vec%0d rdata got %h exp %h", k, rdata, v.rv);
            end
            if (v.chk == 2 && rdata === v.rv) begin
                n_bad++;
                $display("FAIL vec%0d rdata_undriven got %h exp not %h", k, rdata, v.rv);
            end
        end

        // irq-edge-to-request latency from IDLE
        @(negedge clk); drive(idle_v); IntTaken = 1;
        @(negedge clk); drive(idle_v); address = A; data = 32'h1; MemWrite = 1;
        @(negedge clk); drive(idle_v); address = M; data = 32'h40; MemWrite = 1;
        @(negedge clk); drive(idle_v); irq = 8'h40;
        n = 0;
        do begin
            @(negedge clk);
            irq = 8'h00;
            #1;
            n++;
        end while (!InterruptRequest && n < 10);
        n_vec++;
        if (n != 2 || cause !== 5'd6) begin
            n_bad++;
            $display("FAIL latency got %0d cycles cause %0d exp 2 cycles cause 6", n, cause);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
